// File: rtl/gppcu_alu_seq.sv
// GPPCU ALU command sequencer: drives one shared combinational ALU, owns the NZCV
// flag register and runs single-cycle ops plus shift-add unsigned multiplies.
module gppcu_alu_seq #(
  parameter int BW = 32
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iVALID,
  output logic          oREADY,
  input  logic          iCMD,
  input  logic [3:0]    iOP,
  input  logic          iSETF,
  input  logic [BW-1:0] iA,
  input  logic [BW-1:0] iB,
  output logic          oDONE,
  output logic [BW-1:0] oQ,
  output logic [3:0]    oFLAGS,
  output logic [BW-1:0] oALU_A,
  output logic [BW-1:0] oALU_B,
  output logic          oALU_C,
  output logic [3:0]    oALU_OP,
  input  logic [BW-1:0] iALU_Q,
  input  logic          iALU_N,
  input  logic          iALU_Z,
  input  logic          iALU_C,
  input  logic          iALU_V
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b1000;
  localparam logic [3:0] OP_LSL = 4'b1011;

  typedef enum logic [2:0] {IDLE, EXEC, MUL_ADD, MUL_SHL, DONE} state_t;

  state_t        state, stateNext;
  logic [BW-1:0] acc, mcand, mplier, mplierShr;
  logic [3:0]    op;
  logic          setf, accept, opNop;

  // SINGLE commands reuse mcand/mplier as the latched A/B operands.
  assign accept    = iVALID & oREADY;
  assign mplierShr = mplier >> 1;
  assign opNop     = (op == 4'b1110) || (op == 4'b1111);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!iCMD)         stateNext = EXEC;
          else if (iB[0])    stateNext = MUL_ADD;
          else if (iB != '0) stateNext = MUL_SHL;
          else               stateNext = DONE;
        end
      end
      EXEC:    stateNext = DONE;
      MUL_ADD: stateNext = MUL_SHL;
      MUL_SHL: begin
        if (mplierShr == '0)   stateNext = DONE;
        else if (mplierShr[0]) stateNext = MUL_ADD;
        else                   stateNext = MUL_SHL;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    oREADY  = (state == IDLE);
    oDONE   = (state == DONE);
    oALU_OP = OP_NOP;
    oALU_A  = '0;
    oALU_B  = '0;
    oALU_C  = 1'b0;
    case (state)
      EXEC: begin
        oALU_OP = opNop ? OP_NOP : op;
        oALU_A  = mcand;
        oALU_B  = mplier;
        oALU_C  = oFLAGS[1];
      end
      MUL_ADD: begin
        oALU_OP = OP_ADI;
        oALU_A  = acc;
        oALU_B  = mcand;
      end
      MUL_SHL: begin
        oALU_OP = OP_LSL;
        oALU_A  = mcand;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      op     <= '0;
      setf   <= 1'b0;
      oQ     <= '0;
      oFLAGS <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc    <= '0;
            mcand  <= iA;
            mplier <= iB;
            op     <= iOP;
            setf   <= iSETF;
            // A zero multiplier goes straight to DONE, so its result (0) is committed here.
            if (iCMD && (iB == '0)) begin
              oQ     <= '0;
              oFLAGS <= 4'b0100;
            end
          end
        end
        EXEC: begin
          oQ <= opNop ? '0 : iALU_Q;
          if (setf) oFLAGS <= opNop ? 4'b0000 : {iALU_N, iALU_Z, iALU_C, iALU_V};
        end
        MUL_ADD: acc <= iALU_Q;
        MUL_SHL: begin
          mcand  <= iALU_Q;
          mplier <= mplierShr;
          if (mplierShr == '0) begin
            oQ     <= acc;
            oFLAGS <= {acc[BW-1], acc == '0, 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gppcu_alu_seq.sv
// Self-checking bench for gppcu_alu_seq: a behavioural ALU closes the loop and a
// scoreboard queue holds the expected result, flags, latency and ALU-op trace per command.
module tb_gppcu_alu_seq;
  localparam int BW = 32;
  localparam logic [3:0] OP_ADC = 4'b0010;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_ADI = 4'b1000;
  localparam logic [3:0] OP_LSL = 4'b1011;

  logic          iCLK = 1'b0, iRST = 1'b1, iVALID = 1'b0, iCMD = 1'b0, iSETF = 1'b0;
  logic [3:0]    iOP = '0;
  logic [BW-1:0] iA = '0, iB = '0;
  logic          oREADY, oDONE, oALU_C;
  logic [BW-1:0] oQ, oALU_A, oALU_B, iALU_Q;
  logic [3:0]    oFLAGS, oALU_OP;
  logic          iALU_N, iALU_Z, iALU_C, iALU_V;
  logic [BW+3:0] aluOut;

  typedef struct {
    logic [BW-1:0] q;
    logic [3:0]    f;
    int            lat;
    logic [255:0]  tr;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] flagsModel = '0;
  int         checks = 0;
  int         fails  = 0;

  gppcu_alu_seq #(.BW(BW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .oREADY(oREADY), .iCMD(iCMD),
    .iOP(iOP), .iSETF(iSETF), .iA(iA), .iB(iB), .oDONE(oDONE), .oQ(oQ),
    .oFLAGS(oFLAGS), .oALU_A(oALU_A), .oALU_B(oALU_B), .oALU_C(oALU_C),
    .oALU_OP(oALU_OP), .iALU_Q(iALU_Q), .iALU_N(iALU_N), .iALU_Z(iALU_Z),
    .iALU_C(iALU_C), .iALU_V(iALU_V)
  );

  always #5 iCLK = ~iCLK;

  // Behavioural ALU: returns {N,Z,C,V,Q}; LSL shifts A left by one.
  function automatic logic [BW+3:0] aluRef(input logic [3:0] op, input logic [BW-1:0] a,
                                           input logic [BW-1:0] b, input logic c);
    logic [BW:0]   s;
    logic [BW-1:0] q;
    logic          co, v;
    s = '0; q = '0; co = 1'b0; v = 1'b0;
    case (op)
      OP_ADC: begin
        s  = {1'b0, a} + {1'b0, b} + {{BW{1'b0}}, c};
        q  = s[BW-1:0];
        co = s[BW];
        v  = (a[BW-1] == b[BW-1]) && (q[BW-1] != a[BW-1]);
      end
      OP_ADI: begin
        s  = {1'b0, a} + {1'b0, b};
        q  = s[BW-1:0];
        co = s[BW];
      end
      OP_LSL: begin q = a << 1; co = a[BW-1]; end
      OP_MOV: q = b;
      default: q = '0;
    endcase
    return {q[BW-1], q == '0, co, v, q};
  endfunction

  assign aluOut = aluRef(oALU_OP, oALU_A, oALU_B, oALU_C);
  assign iALU_Q = aluOut[BW-1:0];
  assign {iALU_N, iALU_Z, iALU_C, iALU_V} = aluOut[BW+3:BW];

  function automatic void pushSingle(input logic [3:0] op, input logic setf,
                                     input logic [BW-1:0] a, input logic [BW-1:0] b);
    exp_t          e;
    logic [BW+3:0] r;
    r = aluRef(op, a, b, flagsModel[1]);
    e.lat = 2;
    if (op == 4'b1110 || op == 4'b1111) begin
      e.q = '0; e.f = setf ? 4'b0000 : flagsModel; e.tr = '0;
    end else begin
      e.q = r[BW-1:0]; e.f = setf ? r[BW+3:BW] : flagsModel; e.tr = {252'd0, op};
    end
    flagsModel = e.f;
    sb.push_back(e);
  endfunction

  function automatic void pushMul(input logic [BW-1:0] a, input logic [BW-1:0] b);
    exp_t e;
    int   bl, n;
    bl = 0; n = 0;
    e.q  = a * b;
    e.f  = {e.q[BW-1], e.q == '0, 2'b00};
    e.tr = '0;
    for (int i = 0; i < BW; i++) if (b[i]) bl = i + 1;
    for (int i = 0; i < bl; i++) begin
      if (b[i]) begin e.tr = {e.tr[251:0], OP_ADI}; n++; end
      e.tr = {e.tr[251:0], OP_LSL}; n++;
    end
    e.lat = n + 1;
    flagsModel = e.f;
    sb.push_back(e);
  endfunction

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic sendCmd(input logic cmd, input logic [3:0] op, input logic setf,
                         input logic [BW-1:0] a, input logic [BW-1:0] b, output bit ok);
    iCMD = cmd; iOP = op; iSETF = setf; iA = a; iB = b; iVALID = 1'b1; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (oREADY) begin @(negedge iCLK); ok = 1'b1; break; end
      @(negedge iCLK);
    end
    iVALID = 1'b0;
  endtask

  // Starts in the first cycle after accept; lat = -1 if oDONE never arrives.
  task automatic waitDone(output int lat, output logic [BW-1:0] q, output logic [3:0] f,
                          output logic [255:0] tr);
    lat = -1; q = '0; f = '0; tr = '0;
    for (int i = 1; i <= 80; i++) begin
      if (oDONE) begin lat = i; q = oQ; f = oFLAGS; return; end
      tr = {tr[251:0], oALU_OP};
      @(negedge iCLK);
    end
  endtask

  task automatic runCmd(input logic cmd, input logic [3:0] op, input logic setf,
                        input logic [BW-1:0] a, input logic [BW-1:0] b, output int lat,
                        output logic [BW-1:0] q, output logic [3:0] f, output logic [255:0] tr);
    bit ok;
    if (cmd) pushMul(a, b); else pushSingle(op, setf, a, b);
    sendCmd(cmd, op, setf, a, b, ok);
    if (ok) waitDone(lat, q, f, tr);
    else begin lat = -1; q = '0; f = '0; tr = '0; end
  endtask

  task automatic test_reset;
    iVALID = 1'b1; iCMD = 1'b1; iA = 32'd3; iB = 32'd5;
    repeat (3) @(negedge iCLK);
    iRST = 1'b0; iVALID = 1'b0;
    checks += 4;
    if (oREADY !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", oREADY); end
    if (oDONE !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", oDONE); end
    if (oQ !== '0 || oFLAGS !== 4'b0000) begin
      fails++; $display("FAIL reset_regs got q=%h f=%b exp q=0 f=0000", oQ, oFLAGS);
    end
    if ({oALU_OP, oALU_A, oALU_B, oALU_C} !== '0) begin
      fails++; $display("FAIL reset_alu got op=%b a=%h b=%h c=%b exp all 0", oALU_OP, oALU_A, oALU_B, oALU_C);
    end
  endtask

  task automatic test_single;
    int lat; logic [BW-1:0] q; logic [3:0] f; logic [255:0] tr; bit ok; exp_t e;
    runCmd(1'b0, OP_ADC, 1'b1, 32'hFFFF_FFFF, 32'd1, lat, q, f, tr);
    e = sb.pop_front();
    checks += 4;
    if (lat !== e.lat) begin fails++; $display("FAIL adc1_latency got=%0d exp=%0d", lat, e.lat); end
    if (q !== e.q) begin fails++; $display("FAIL adc1_q got=%h exp=%h", q, e.q); end
    if (f !== e.f) begin fails++; $display("FAIL adc1_flags got=%b exp=%b", f, e.f); end
    if (tr !== e.tr) begin fails++; $display("FAIL adc1_trace got=%h exp=%h", tr, e.tr); end
    @(negedge iCLK);
    pushSingle(OP_ADC, 1'b1, 32'd0, 32'd0);
    sendCmd(1'b0, OP_ADC, 1'b1, 32'd0, 32'd0, ok);
    checks++;
    if (oALU_C !== 1'b1 || !ok) begin fails++; $display("FAIL adc2_carry_in got=%b exp=1", oALU_C); end
    if (ok) waitDone(lat, q, f, tr); else lat = -1;
    e = sb.pop_front();
    checks += 3;
    if (lat !== e.lat) begin fails++; $display("FAIL adc2_latency got=%0d exp=%0d", lat, e.lat); end
    if (q !== e.q) begin fails++; $display("FAIL adc2_q got=%h exp=%h", q, e.q); end
    if (f !== e.f) begin fails++; $display("FAIL adc2_flags got=%b exp=%b", f, e.f); end
  endtask

  task automatic test_nop;
    int lat; logic [BW-1:0] q; logic [3:0] f; logic [255:0] tr; exp_t e;
    logic [3:0] ops [3] = '{OP_ADC, 4'b1111, 4'b1110};
    logic       sf  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      runCmd(1'b0, ops[i], sf[i], 32'hFFFF_FFFF, 32'd0, lat, q, f, tr);
      e = sb.pop_front();
      checks += 3;
      if (q !== e.q) begin fails++; $display("FAIL nop%0d_q got=%h exp=%h", i, q, e.q); end
      if (f !== e.f) begin fails++; $display("FAIL nop%0d_flags got=%b exp=%b", i, f, e.f); end
      if (tr !== e.tr || lat !== e.lat) begin
        fails++; $display("FAIL nop%0d_trace got=%h/%0d exp=%h/%0d", i, tr, lat, e.tr, e.lat);
      end
      @(negedge iCLK);
    end
  endtask

  task automatic test_mul;
    int lat; logic [BW-1:0] q; logic [3:0] f; logic [255:0] tr; exp_t e;
    logic [BW-1:0] as [3] = '{32'd3, 32'hFFFF_FFFF, 32'd7};
    logic [BW-1:0] bs [3] = '{32'd5, 32'd2, 32'd0};
    for (int i = 0; i < 3; i++) begin
      runCmd(1'b1, 4'b0000, 1'b0, as[i], bs[i], lat, q, f, tr);
      e = sb.pop_front();
      checks += 4;
      if (lat !== e.lat) begin fails++; $display("FAIL mul%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
      if (q !== e.q) begin fails++; $display("FAIL mul%0d_q got=%h exp=%h", i, q, e.q); end
      if (f !== e.f) begin fails++; $display("FAIL mul%0d_flags got=%b exp=%b", i, f, e.f); end
      if (tr !== e.tr) begin fails++; $display("FAIL mul%0d_trace got=%h exp=%h", i, tr, e.tr); end
      @(negedge iCLK);
    end
  endtask

  task automatic test_busy;
    int lat; logic [BW-1:0] q; logic [3:0] f; logic [255:0] tr; bit ok; exp_t e;
    pushMul(32'd3, 32'd5);
    sendCmd(1'b1, 4'b0000, 1'b0, 32'd3, 32'd5, ok);
    iCMD = 1'b0; iOP = OP_MOV; iSETF = 1'b0; iA = '0; iB = 32'd9; iVALID = 1'b1;
    checks++;
    if (oREADY !== 1'b0 || !ok) begin fails++; $display("FAIL busy_ready got=%b exp=0", oREADY); end
    waitDone(lat, q, f, tr);
    e = sb.pop_front();
    checks += 2;
    if (q !== e.q || lat !== e.lat) begin
      fails++; $display("FAIL busy_mul got q=%h lat=%0d exp q=%h lat=%0d", q, lat, e.q, e.lat);
    end
    if (tr !== e.tr) begin fails++; $display("FAIL busy_trace got=%h exp=%h", tr, e.tr); end
    pushSingle(OP_MOV, 1'b0, '0, 32'd9);
    @(negedge iCLK);
    checks++;
    if (oREADY !== 1'b1) begin fails++; $display("FAIL busy_ready_after got=%b exp=1", oREADY); end
    @(negedge iCLK);
    iVALID = 1'b0;
    waitDone(lat, q, f, tr);
    e = sb.pop_front();
    checks += 3;
    if (lat !== e.lat) begin fails++; $display("FAIL busy_mov_latency got=%0d exp=%0d", lat, e.lat); end
    if (q !== e.q) begin fails++; $display("FAIL busy_mov_q got=%h exp=%h", q, e.q); end
    if (f !== e.f) begin fails++; $display("FAIL busy_mov_flags got=%b exp=%b", f, e.f); end
    @(negedge iCLK);
  endtask

  task automatic test_reset_midop;
    bit ok; bit doneSeen;
    sendCmd(1'b1, 4'b0000, 1'b0, 32'd3, 32'd5, ok);
    @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    flagsModel = '0;
    checks += 3;
    if (oREADY !== 1'b1 || oDONE !== 1'b0 || !ok) begin
      fails++; $display("FAIL midrst_ready got ready=%b done=%b exp 1/0", oREADY, oDONE);
    end
    if (oQ !== '0 || oFLAGS !== 4'b0000) begin
      fails++; $display("FAIL midrst_regs got q=%h f=%b exp q=0 f=0000", oQ, oFLAGS);
    end
    if ({oALU_OP, oALU_A, oALU_B, oALU_C} !== '0) begin
      fails++; $display("FAIL midrst_alu got op=%b a=%h b=%h c=%b exp all 0", oALU_OP, oALU_A, oALU_B, oALU_C);
    end
    doneSeen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (oDONE) doneSeen = 1'b1;
      @(negedge iCLK);
    end
    checks++;
    if (doneSeen !== 1'b0) begin fails++; $display("FAIL midrst_no_done got=%b exp=0", doneSeen); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [BW-1:0] q; logic [3:0] f; logic [255:0] tr; exp_t e;
    logic [BW-1:0] a, b; logic cmd, sf;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; cmd = i[0]; sf = $urandom_range(0, 1) == 1;
      b = cmd ? 32'($urandom_range(0, 16'hFFFF)) : $urandom;
      runCmd(cmd, cmd ? 4'b0000 : OP_ADC, sf, a, b, lat, q, f, tr);
      e = sb.pop_front();
      checks += 3;
      if (lat !== e.lat) begin fails++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
      if (q !== e.q) begin fails++; $display("FAIL b2b%0d_q got=%h exp=%h", i, q, e.q); end
      if (f !== e.f) begin fails++; $display("FAIL b2b%0d_flags got=%b exp=%b", i, f, e.f); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge iCLK);
    test_reset();
    test_single();
    test_nop();
    test_mul();
    test_busy();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
